// File: rtl/tf_ctrl_pkg.sv
// Shared types and default constants for the twiddle-factor stage sequencer.
// stage_cycles() gives the stall-free length of one stage for a parameter set.
package tf_ctrl_pkg;

   localparam int D_WIDTH_DEF    = 64;
   localparam int NUM_STAGES_DEF = 4;
   localparam int DEPTH_CNT_DEF  = 4;
   localparam int ITE_CNT_DEF    = 16;
   localparam int WEN_DELAY_DEF  = 3;
   localparam int PIPE_LAT_DEF   = 4;
   localparam int TMR_W          = 8;

   typedef enum logic [2:0] {
      IDLE,
      WLOAD,
      WWAIT,
      RUN,
      DRAIN,
      DONE
   } state_e;

   function automatic int stage_cycles(input int wen_delay, input int depth_cnt,
                                       input int ite_cnt, input int pipe_lat);
      return 1 + (wen_delay + 1) + depth_cnt * ite_cnt + pipe_lat;
   endfunction

endpackage

// File: rtl/tf_loop_cnt.sv
// Nested iteration counter: ite wraps into depth, ite3 counts completed octets of ite.
// Cleared by clr, stepped by adv; last flags the final (depth, ite) position.
module tf_loop_cnt #(
   parameter int D_WIDTH   = 64,
   parameter int DEPTH_CNT = 4,
   parameter int ITE_CNT   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               adv,
   output logic [D_WIDTH-1:0] ite,
   output logic [2:0]         depth,
   output logic [D_WIDTH-1:0] ite3,
   output logic               last
);

   localparam logic [D_WIDTH-1:0] ITE_MAX   = D_WIDTH'(ITE_CNT - 1);
   localparam logic [2:0]         DEPTH_MAX = 3'(DEPTH_CNT - 1);

   assign last = (depth == DEPTH_MAX) && (ite == ITE_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ite   <= '0;
         depth <= '0;
         ite3  <= '0;
      end else if (clr) begin
         ite   <= '0;
         depth <= '0;
         ite3  <= '0;
      end else if (adv) begin
         if (ite == ITE_MAX) begin
            ite   <= '0;
            depth <= (depth == DEPTH_MAX) ? 3'd0 : depth + 3'd1;
         end else begin
            ite <= ite + 1'b1;
         end
         if (ite[2:0] == 3'd7) begin
            ite3 <= ite3 + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tf_stage_ctrl.sv
// Stage sequencer for the twiddle-factor generator: loads the base TF, waits out the
// write delay, streams DEPTH_CNT*ITE_CNT reads, drains the pipeline, repeats per stage.
//
// state | meaning
// IDLE  | waiting for start; stage index held at 0
// WLOAD | one-cycle base-TF write strobe
// WWAIT | WEN_DELAY+1 cycles for the delayed write to land
// RUN   | one read per non-stalled cycle, counters step after each read
// DRAIN | PIPE_LAT cycles for the last reads to leave the generator
// DONE  | one-cycle done pulse
module tf_stage_ctrl
   import tf_ctrl_pkg::*;
#(
   parameter int D_WIDTH    = D_WIDTH_DEF,
   parameter int NUM_STAGES = NUM_STAGES_DEF,
   parameter int DEPTH_CNT  = DEPTH_CNT_DEF,
   parameter int ITE_CNT    = ITE_CNT_DEF,
   parameter int WEN_DELAY  = WEN_DELAY_DEF,
   parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stall,
   output logic               busy,
   output logic               done,
   output logic               TF_wen,
   output logic               TF_ren,
   output logic               LAST_STAGE,
   output logic [2:0]         l,
   output logic [2:0]         it_depth_cnt,
   output logic [D_WIDTH-1:0] ite_sw_cnt,
   output logic [D_WIDTH-1:0] ite_sw_cnt_ite3
);

   state_e           state, state_nxt;
   logic [TMR_W-1:0] tmr, tmr_nxt;
   logic [2:0]       l_nxt;
   logic             clr, adv, cnt_last;

   tf_loop_cnt #(
      .D_WIDTH   (D_WIDTH),
      .DEPTH_CNT (DEPTH_CNT),
      .ITE_CNT   (ITE_CNT)
   ) u_loop_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .adv   (adv),
      .ite   (ite_sw_cnt),
      .depth (it_depth_cnt),
      .ite3  (ite_sw_cnt_ite3),
      .last  (cnt_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         tmr   <= '0;
         l     <= '0;
      end else begin
         state <= state_nxt;
         tmr   <= tmr_nxt;
         l     <= l_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      l_nxt     = l;
      clr       = 1'b0;
      adv       = 1'b0;
      case (state)
         IDLE: begin
            l_nxt = '0;
            if (start) begin
               state_nxt = WLOAD;
               clr       = 1'b1;
            end
         end
         WLOAD: begin
            state_nxt = WWAIT;
            tmr_nxt   = TMR_W'(WEN_DELAY);
         end
         WWAIT: begin
            if (tmr == '0) state_nxt = RUN;
            else           tmr_nxt   = tmr - 1'b1;
         end
         RUN: begin
            // the final read leaves the counters on their last position
            if (!stall) begin
               if (cnt_last) begin
                  state_nxt = DRAIN;
                  tmr_nxt   = TMR_W'(PIPE_LAT - 1);
               end else begin
                  adv = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (tmr != '0) begin
               tmr_nxt = tmr - 1'b1;
            end else if (LAST_STAGE) begin
               state_nxt = DONE;
            end else begin
               state_nxt = WLOAD;
               l_nxt     = l + 3'd1;
               clr       = 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            l_nxt     = '0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign TF_wen     = (state == WLOAD);
   // stall gates the read strobe in the same cycle so a frozen cycle issues no read
   assign TF_ren     = (state == RUN) && !stall;
   assign LAST_STAGE = (l == 3'(NUM_STAGES - 1));

endmodule
